// File: rtl/tl_get_fragmenter.sv
// TileLink A/D adapter that splits multi-beat Gets into single-word (4 B) Gets and
// forwards every other request unchanged; one upstream transaction in flight at a time.
module tl_get_fragmenter #(
    parameter int ADDR_W     = 14,
    parameter int SRC_W      = 5,
    parameter int MAX_LGSIZE = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    // upstream A
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [2:0]        a_opcode,
    input  logic [2:0]        a_param,
    input  logic [2:0]        a_size,
    input  logic [SRC_W-1:0]  a_source,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [3:0]        a_mask,
    input  logic [31:0]       a_data,
    input  logic              a_corrupt,
    // upstream D
    output logic              d_valid,
    input  logic              d_ready,
    output logic [2:0]        d_opcode,
    output logic [2:0]        d_size,
    output logic [SRC_W-1:0]  d_source,
    output logic [31:0]       d_data,
    output logic              d_denied,
    output logic              d_corrupt,
    // downstream A
    output logic              o_a_valid,
    input  logic              o_a_ready,
    output logic [2:0]        o_a_opcode,
    output logic [2:0]        o_a_param,
    output logic [2:0]        o_a_size,
    output logic [SRC_W-1:0]  o_a_source,
    output logic [ADDR_W-1:0] o_a_address,
    output logic [3:0]        o_a_mask,
    output logic [31:0]       o_a_data,
    output logic              o_a_corrupt,
    // downstream D
    input  logic              o_d_valid,
    output logic              o_d_ready,
    input  logic [2:0]        o_d_opcode,
    input  logic [2:0]        o_d_size,
    input  logic [SRC_W-1:0]  o_d_source,
    input  logic [31:0]       o_d_data,
    input  logic              o_d_denied,
    input  logic              o_d_corrupt
);

    typedef enum logic [1:0] {IDLE, SEND, RESP} state_e;

    localparam logic [2:0] OP_GET = 3'd4;
    localparam logic [2:0] MAX_SZ = 3'(MAX_LGSIZE);

    state_e            state_q, state_d;
    logic [2:0]        opcode_q, opcode_d;
    logic [2:0]        param_q, param_d;
    logic [2:0]        size_q, size_d;
    logic [SRC_W-1:0]  source_q, source_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [3:0]        mask_q, mask_d;
    logic [31:0]       data_q, data_d;
    logic              corrupt_q, corrupt_d;
    logic              frag_q, frag_d;
    logic [3:0]        last_q, last_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              denied_q, denied_d;

    logic [2:0]        lg_sz;
    logic              last_beat;
    logic [ADDR_W-1:0] beat_off;

    // Downstream response size/source are implied by the saved request.
    logic              unused_d_fields;
    assign unused_d_fields = ^{o_d_size, o_d_source};

    assign last_beat = !frag_q || (cnt_q == last_q);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        opcode_d  = opcode_q;
        param_d   = param_q;
        size_d    = size_q;
        source_d  = source_q;
        address_d = address_q;
        mask_d    = mask_q;
        data_d    = data_q;
        corrupt_d = corrupt_q;
        frag_d    = frag_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        denied_d  = denied_q;
        lg_sz     = (a_size > MAX_SZ) ? MAX_SZ : a_size;

        unique case (state_q)
            IDLE: begin
                if (a_valid) begin
                    opcode_d  = a_opcode;
                    param_d   = a_param;
                    size_d    = a_size;
                    source_d  = a_source;
                    address_d = a_address;
                    mask_d    = a_mask;
                    data_d    = a_data;
                    corrupt_d = a_corrupt;
                    frag_d    = (a_opcode == OP_GET) && (a_size > 3'd2);
                    // 2^(lg-2)-1 computed 5 bits wide so 16 beats yields index 15
                    last_d    = 4'((5'd1 << (lg_sz - 3'd2)) - 5'd1);
                    cnt_d     = '0;
                    denied_d  = 1'b0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (o_a_ready) state_d = RESP;
            end
            RESP: begin
                if (o_d_valid && d_ready) begin
                    if (o_d_denied) denied_d = 1'b1;
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            opcode_q  <= '0;
            param_q   <= '0;
            size_q    <= '0;
            source_q  <= '0;
            address_q <= '0;
            mask_q    <= '0;
            data_q    <= '0;
            corrupt_q <= 1'b0;
            frag_q    <= 1'b0;
            last_q    <= '0;
            cnt_q     <= '0;
            denied_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            param_q   <= param_d;
            size_q    <= size_d;
            source_q  <= source_d;
            address_q <= address_d;
            mask_q    <= mask_d;
            data_q    <= data_d;
            corrupt_q <= corrupt_d;
            frag_q    <= frag_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            denied_q  <= denied_d;
        end
    end

    // Outputs are gated by state so nothing stale leaks while idle or in reset.
    always_comb begin
        a_ready     = reset_n && (state_q == IDLE);
        beat_off    = frag_q ? ADDR_W'({cnt_q, 2'b00}) : '0;

        o_a_valid   = 1'b0;
        o_a_opcode  = '0;
        o_a_param   = '0;
        o_a_size    = '0;
        o_a_source  = '0;
        o_a_address = '0;
        o_a_mask    = '0;
        o_a_data    = '0;
        o_a_corrupt = 1'b0;
        if (state_q == SEND) begin
            o_a_valid   = 1'b1;
            o_a_opcode  = frag_q ? OP_GET : opcode_q;
            o_a_param   = param_q;
            o_a_size    = frag_q ? 3'd2 : size_q;
            o_a_source  = source_q;
            o_a_address = address_q + beat_off;
            o_a_mask    = frag_q ? 4'hF : mask_q;
            o_a_data    = data_q;
            o_a_corrupt = corrupt_q;
        end

        d_valid   = 1'b0;
        o_d_ready = 1'b0;
        d_opcode  = '0;
        d_size    = '0;
        d_source  = '0;
        d_data    = '0;
        d_denied  = 1'b0;
        d_corrupt = 1'b0;
        if (state_q == RESP) begin
            d_valid   = o_d_valid;
            o_d_ready = d_ready;
            d_opcode  = o_d_opcode;
            d_size    = size_q;
            d_source  = source_q;
            d_data    = o_d_data;
            d_denied  = o_d_denied | denied_q;
            d_corrupt = o_d_corrupt | o_d_denied | denied_q;
        end
    end

endmodule
